arrow_game_controller: RTL and testbench

//  Sequences the arrow-rhythm game: runs the IDLE/GAME/PAUSE/OVER state machine and, on each metronome

---
 rtl/arrow_game_controller_pkg.sv | 31 +++
 rtl/arrow_game_controller_sync_rise_detect.sv | 27 ++
 rtl/arrow_game_controller.sv | 155 +++++++++++++++
 tb/tb_arrow_game_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_game_controller_pkg.sv
// rtl/arrow_game_controller_pkg.sv - shared state/arrow codes and LFSR helpers for the arrow game
package arrow_game_controller_pkg;

    localparam int STATE_BITS      = 1;
    localparam int NUM_ARROWS_BITS = 4;

    typedef enum logic [STATE_BITS:0] {
        STATE_IDLE  = 2'd0,
        STATE_GAME  = 2'd1,
        STATE_PAUSE = 2'd2,
        STATE_OVER  = 2'd3
    } game_state_t;

    localparam logic [NUM_ARROWS_BITS:0] ARROW_UP    = 5'd10;
    localparam logic [NUM_ARROWS_BITS:0] ARROW_DOWN  = 5'd11;
    localparam logic [NUM_ARROWS_BITS:0] ARROW_LEFT  = 5'd12;
    localparam logic [NUM_ARROWS_BITS:0] ARROW_RIGHT = 5'd13;
    localparam logic [NUM_ARROWS_BITS:0] ARROW_NONE  = 5'd20;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_advance(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // A quarter of beats are empty; otherwise the low two bits pick the direction.
    function automatic logic [NUM_ARROWS_BITS:0] arrow_from_lfsr(input logic [15:0] l);
        return (l[3:2] == 2'b00) ? ARROW_NONE : ARROW_UP + {3'b000, l[1:0]};
    endfunction

endpackage

// File: rtl/arrow_game_controller_sync_rise_detect.sv
// rtl/arrow_game_controller_sync_rise_detect.sv - 2-FF synchronizer with registered rising-edge pulse
module sync_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic s_meta;
    logic s_sync;
    logic s_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_prev <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            s_meta <= async_in;
            s_sync <= s_meta;
            s_prev <= s_sync;
            pulse  <= s_sync & ~s_prev;
        end
    end

endmodule

// File: rtl/arrow_game_controller.sv
// rtl/arrow_game_controller.sv - arrow-rhythm game FSM, arrow queue, judgement, lives/score/combo
module arrow_game_controller
    import arrow_game_controller_pkg::*;
#(
    parameter logic [2:0]  LIVES_INIT = 3'd5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [13:0] SCORE_MAX  = 14'd9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        metronome_clk,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic [3:0]  btn_dir,
    output logic [1:0]  state,
    output logic [4:0]  cur_arrow0,
    output logic [4:0]  cur_arrow1,
    output logic [4:0]  cur_arrow2,
    output logic [4:0]  cur_arrow3,
    output logic [2:0]  lives,
    output logic [13:0] score,
    output logic [13:0] combo,
    output logic        judge_valid,
    output logic        judge_hit
);

    logic       tick_p;
    logic       start_p;
    logic       pause_p;
    logic [3:0] dir_p;

    sync_rise_detect u_sync_tick  (.clk(clk), .rst(rst), .async_in(metronome_clk), .pulse(tick_p));
    sync_rise_detect u_sync_start (.clk(clk), .rst(rst), .async_in(btn_start),     .pulse(start_p));
    sync_rise_detect u_sync_pause (.clk(clk), .rst(rst), .async_in(btn_pause),     .pulse(pause_p));

    for (genvar g = 0; g < 4; g++) begin : g_dir
        sync_rise_detect u_sync_dir (.clk(clk), .rst(rst), .async_in(btn_dir[g]), .pulse(dir_p[g]));
    end

    game_state_t               state_q, state_d;
    logic [NUM_ARROWS_BITS:0]  arrow_q [4];
    logic [NUM_ARROWS_BITS:0]  arrow_d [4];
    logic                      hit_q, hit_d, miss_q, miss_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic [2:0]                lives_q, lives_d;
    logic [13:0]               score_q, score_d, combo_q, combo_d;
    logic                      jv_q, jv_d, jh_q, jh_d;

    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (v >= SCORE_MAX) ? SCORE_MAX : v + 14'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            for (int i = 0; i < 4; i++) arrow_q[i] <= ARROW_NONE;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            lives_q <= LIVES_INIT;
            score_q <= '0;
            combo_q <= '0;
            jv_q    <= 1'b0;
            jh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            arrow_q <= arrow_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            lfsr_q  <= lfsr_d;
            lives_q <= lives_d;
            score_q <= score_d;
            combo_q <= combo_d;
            jv_q    <= jv_d;
            jh_q    <= jh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arrow_d = arrow_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        lfsr_d  = lfsr_q;
        lives_d = lives_q;
        score_d = score_q;
        combo_d = combo_q;
        jv_d    = 1'b0;
        jh_d    = 1'b0;
        unique case (state_q)
            STATE_IDLE: begin
                if (start_p) begin
                    state_d = STATE_GAME;
                    for (int i = 0; i < 4; i++) arrow_d[i] = ARROW_NONE;
                    hit_d   = 1'b0;
                    miss_d  = 1'b0;
                    lfsr_d  = LFSR_SEED;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                    combo_d = '0;
                end
            end
            STATE_GAME: begin
                if (tick_p) begin
                    if (arrow_q[3] != ARROW_NONE && hit_q && !miss_q) begin
                        score_d = sat_inc(score_q);
                        combo_d = sat_inc(combo_q);
                        jv_d    = 1'b1;
                        jh_d    = 1'b1;
                    end else if (arrow_q[3] != ARROW_NONE || miss_q) begin
                        lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                        combo_d = '0;
                        jv_d    = 1'b1;
                    end
                    arrow_d[3] = arrow_q[2];
                    arrow_d[2] = arrow_q[1];
                    arrow_d[1] = arrow_q[0];
                    arrow_d[0] = arrow_from_lfsr(lfsr_q);
                    lfsr_d     = lfsr_advance(lfsr_q);
                    hit_d      = 1'b0;
                    miss_d     = 1'b0;
                end
                // Presses coinciding with a tick belong to the beat that has just moved to the front.
                for (int i = 0; i < 4; i++) begin
                    if (dir_p[i]) begin
                        if (arrow_d[3] == ARROW_UP + 5'(i)) hit_d  = 1'b1;
                        else                                 miss_d = 1'b1;
                    end
                end
                if (lives_d == 3'd0)  state_d = STATE_OVER;
                else if (pause_p)     state_d = STATE_PAUSE;
            end
            STATE_PAUSE: begin
                if (start_p)      state_d = STATE_IDLE;
                else if (pause_p) state_d = STATE_GAME;
            end
            STATE_OVER: begin
                if (start_p) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    assign state       = state_q;
    assign cur_arrow0  = arrow_q[0];
    assign cur_arrow1  = arrow_q[1];
    assign cur_arrow2  = arrow_q[2];
    assign cur_arrow3  = arrow_q[3];
    assign lives       = lives_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign judge_valid = jv_q;
    assign judge_hit   = jh_q;

endmodule

// File: tb/tb_arrow_game_controller.sv
// tb/tb_arrow_game_controller.sv - directed plus randomized self-checking bench for arrow_game_controller
module tb_arrow_game_controller;

    localparam int S_IDLE = 0, S_GAME = 1, S_PAUSE = 2, S_OVER = 3;
    localparam int A_UP = 10, A_DOWN = 11, A_LEFT = 12, A_RIGHT = 13, A_NONE = 20;
    localparam int TB_SCORE_MAX = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        metronome_clk, btn_start, btn_pause;
    logic [3:0]  btn_dir;
    logic [1:0]  state;
    logic [4:0]  cur_arrow0, cur_arrow1, cur_arrow2, cur_arrow3;
    logic [2:0]  lives;
    logic [13:0] score, combo;
    logic        judge_valid, judge_hit;

    int errors = 0;
    int checks = 0;

    int m_state, m_lives, m_score, m_combo, m_lfsr;
    int m_q[4];
    bit m_hit, m_miss, m_jv, m_jh;

    arrow_game_controller #(
        .LIVES_INIT(3'd5),
        .LFSR_SEED (16'hACE1),
        .SCORE_MAX (14'(TB_SCORE_MAX))
    ) dut (
        .clk(clk), .rst(rst), .metronome_clk(metronome_clk),
        .btn_start(btn_start), .btn_pause(btn_pause), .btn_dir(btn_dir),
        .state(state), .cur_arrow0(cur_arrow0), .cur_arrow1(cur_arrow1),
        .cur_arrow2(cur_arrow2), .cur_arrow3(cur_arrow3), .lives(lives),
        .score(score), .combo(combo), .judge_valid(judge_valid), .judge_hit(judge_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, 32'(state), m_state);
        check({tag, ".lives"}, 32'(lives), m_lives);
        check({tag, ".score"}, 32'(score), m_score);
        check({tag, ".combo"}, 32'(combo), m_combo);
        check({tag, ".arrow0"}, 32'(cur_arrow0), m_q[0]);
        check({tag, ".arrow1"}, 32'(cur_arrow1), m_q[1]);
        check({tag, ".arrow2"}, 32'(cur_arrow2), m_q[2]);
        check({tag, ".arrow3"}, 32'(cur_arrow3), m_q[3]);
        check({tag, ".jv"}, 32'(judge_valid), 32'(m_jv));
        check({tag, ".jh"}, 32'(judge_hit), 32'(m_jh));
    endtask

    function automatic void model_load();
        m_lives = 5; m_score = 0; m_combo = 0; m_lfsr = 'hACE1;
        m_hit = 0; m_miss = 0;
        for (int i = 0; i < 4; i++) m_q[i] = A_NONE;
    endfunction

    function automatic void model_reset();
        model_load();
        m_state = S_IDLE; m_jv = 0; m_jh = 0;
    endfunction

    function automatic void model_apply(input bit t, input bit st, input bit pa, input bit [3:0] d);
        int gen;
        m_jv = 0; m_jh = 0;
        case (m_state)
            S_IDLE: if (st) begin model_load(); m_state = S_GAME; end
            S_GAME: begin
                if (t) begin
                    if (m_q[3] != A_NONE && m_hit && !m_miss) begin
                        m_score = (m_score + 1 > TB_SCORE_MAX) ? TB_SCORE_MAX : m_score + 1;
                        m_combo = (m_combo + 1 > TB_SCORE_MAX) ? TB_SCORE_MAX : m_combo + 1;
                        m_jv = 1; m_jh = 1;
                    end else if (m_q[3] != A_NONE || m_miss) begin
                        if (m_lives > 0) m_lives--;
                        m_combo = 0; m_jv = 1;
                    end
                    gen = ((m_lfsr % 16) / 4 == 0) ? A_NONE : A_UP + (m_lfsr % 4);
                    m_q[3] = m_q[2]; m_q[2] = m_q[1]; m_q[1] = m_q[0]; m_q[0] = gen;
                    m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 'hB400 : 0);
                    m_hit = 0; m_miss = 0;
                end
                for (int i = 0; i < 4; i++)
                    if (d[i]) begin
                        if (m_q[3] == A_UP + i) m_hit = 1;
                        else                    m_miss = 1;
                    end
                if (m_lives == 0) m_state = S_OVER;
                else if (pa)      m_state = S_PAUSE;
            end
            S_PAUSE: if (st) m_state = S_IDLE; else if (pa) m_state = S_GAME;
            default: if (st) m_state = S_IDLE;
        endcase
    endfunction

    // Raw rise is acted on by the DUT at the 4th clock edge after it is applied.
    task automatic step(input bit t, input bit st, input bit pa, input bit [3:0] d);
        metronome_clk = t; btn_start = st; btn_pause = pa; btn_dir = d;
        repeat (4) @(posedge clk);
        #1;
        model_apply(t, st, pa, d);
        check_all("step");
        @(posedge clk);
        #1;
        check("judge_pulse_width", 32'(judge_valid), 0);
        m_jv = 0; m_jh = 0;
        metronome_clk = 0; btn_start = 0; btn_pause = 0; btn_dir = 4'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic beat_correct();
        if (m_q[3] != A_NONE) step(0, 0, 0, 4'(1 << (m_q[3] - A_UP)));
        step(1, 0, 0, 4'b0);
    endtask

    task automatic beat_wrong();
        if (m_q[3] == A_NONE) step(0, 0, 0, 4'b0010);
        else                  step(0, 0, 0, 4'(1 << ((m_q[3] - A_UP + 1) % 4)));
        step(1, 0, 0, 4'b0);
    endtask

    initial begin
        int extra;
        int snap_score, snap_lives;
        rst = 1; metronome_clk = 0; btn_start = 0; btn_pause = 0; btn_dir = 4'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;

        step(0, 1, 0, 4'b0);
        check("start_to_game", 32'(state), S_GAME);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'b0);
        check("seed_arrow3", 32'(cur_arrow3), A_NONE);
        check("seed_arrow2", 32'(cur_arrow2), A_NONE);
        check("seed_arrow1", 32'(cur_arrow1), A_UP);
        check("seed_arrow0", 32'(cur_arrow0), A_UP);
        check("seed_lives", 32'(lives), 5);

        step(1, 0, 0, 4'b0);
        check("none_no_press_lives", 32'(lives), 5);
        step(0, 0, 0, 4'b0010);
        step(1, 0, 0, 4'b0);
        check("none_press_lives", 32'(lives), 4);

        check("front_up", 32'(cur_arrow3), A_UP);
        step(0, 0, 0, 4'b0001);
        step(1, 0, 0, 4'b0);
        check("hit_score", 32'(score), 1);
        check("hit_combo", 32'(combo), 1);
        beat_correct();
        check("front_left", 32'(cur_arrow3), A_LEFT);
        step(0, 0, 0, 4'b0100);
        step(0, 0, 0, 4'b1000);
        step(1, 0, 0, 4'b0);
        check("double_press_lives", 32'(lives), 3);
        check("double_press_combo", 32'(combo), 0);

        extra = 0;
        for (int i = 0; i < 60 && extra < 3; i++) begin
            if (m_score == TB_SCORE_MAX && m_q[3] != A_NONE) extra++;
            beat_correct();
        end
        check("sat_score", 32'(score), TB_SCORE_MAX);
        check("sat_combo", 32'(combo), TB_SCORE_MAX);

        step(0, 0, 1, 4'b0);
        check("paused", 32'(state), S_PAUSE);
        snap_score = m_score; snap_lives = m_lives;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 4'b0001);
        check("pause_frozen_score", 32'(score), snap_score);
        check("pause_frozen_lives", 32'(lives), snap_lives);
        step(0, 0, 1, 4'b0);
        check("resumed", 32'(state), S_GAME);
        step(1, 0, 1, 4'b0);
        check("tick_pause_state", 32'(state), S_PAUSE);
        step(0, 1, 1, 4'b0);
        check("start_beats_pause", 32'(state), S_IDLE);
        step(0, 1, 0, 4'b0);
        check("restart_lives", 32'(lives), 5);

        for (int i = 0; i < 40 && m_state != S_OVER; i++) beat_wrong();
        check("over_state", 32'(state), S_OVER);
        check("over_lives", 32'(lives), 0);
        snap_score = m_score;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 4'b1111);
        check("over_hold_lives", 32'(lives), 0);
        check("over_hold_score", 32'(score), snap_score);
        step(0, 1, 0, 4'b0);
        check("over_to_idle", 32'(state), S_IDLE);

        for (int i = 0; i < 90; i++) begin
            bit t, st, pa;
            bit [3:0] d;
            t  = 1'($urandom_range(0, 1));
            st = (m_state == S_IDLE || m_state == S_OVER) ? ($urandom_range(0, 2) == 0)
                                                          : ($urandom_range(0, 14) == 0);
            pa = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       d = 4'b0;
                1:       d = 4'($urandom_range(0, 15));
                default: d = (m_q[3] != A_NONE) ? 4'(1 << (m_q[3] - A_UP)) : 4'b0;
            endcase
            step(t, st, pa, d);
        end

        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        step(0, 1, 0, 4'b0);
        for (int i = 0; i < 3; i++) beat_correct();
        beat_wrong();
        @(posedge clk);
        #3;
        rst = 1;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("reset_next_clk");
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
